// File: rtl/alu_issue_arbiter_pkg.sv
// alu_issue_arbiter_pkg: shared sizes and the round-robin pick helper for the ALU issue arbiter.
package alu_issue_arbiter_pkg;
  localparam int NUM_OC = 4;
  localparam int SEL_W = $clog2(NUM_OC);
  localparam int NUM_WARPS = 8;
  localparam int WID_W = 3;
  localparam int MAX_OC = 8;
  // Isolates the lowest set bit; callers rotate so that bit 0 is the rr_ptr position.
  function automatic logic [MAX_OC-1:0] first_one_hot(input logic [MAX_OC-1:0] v);
    return v & (~v + MAX_OC'(1));
  endfunction
endpackage

// File: rtl/alu_issue_arbiter_rr_pick.sv
// alu_issue_arbiter_rr_pick: rotate / priority-pick / rotate-back round-robin selector.
module alu_issue_arbiter_rr_pick
  import alu_issue_arbiter_pkg::MAX_OC;
  import alu_issue_arbiter_pkg::first_one_hot;
#(
  parameter int N = alu_issue_arbiter_pkg::NUM_OC,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] back;
  logic [N-1:0] rot;
  logic [N-1:0] rot_oh;
  logic [MAX_OC-1:0] oh_full;
  always_comb begin
    dbl = {elig, elig};
    rot = dbl[{1'b0, ptr} +: N];
    oh_full = first_one_hot(MAX_OC'(rot));
    rot_oh = oh_full[N-1:0];
    back = {rot_oh, rot_oh} << ptr;
    gnt = back[2*N-1:N];
    idx = '0;
    for (int i = 0; i < N; i++) if (gnt[i]) idx = W'(i);
    any = |elig;
  end
endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of OC entries to the shared ALU with
// MULT CDB-slot and per-warp branch-pending hazard masking.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::WID_W;
#(
  parameter int NUM_OC = alu_issue_arbiter_pkg::NUM_OC,
  parameter int NUM_WARPS = alu_issue_arbiter_pkg::NUM_WARPS,
  localparam int SEL_W = $clog2(NUM_OC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_OC-1:0]       Req_OC_Arb,
  input  logic [WID_W*NUM_OC-1:0] WarpID_OC_Arb,
  input  logic [NUM_OC-1:0]       IsBr_OC_Arb,
  input  logic [NUM_OC-1:0]       RegWrite_OC_Arb,
  input  logic                    MULT_WB_Next,
  input  logic                    Br_Done_SIMT,
  input  logic [WID_W-1:0]        Br_Done_WarpID_SIMT,
  output logic [NUM_OC-1:0]       Grant_Arb_OC,
  output logic                    Valid_OC_ALU,
  output logic [SEL_W-1:0]        Sel_OC_ALU,
  output logic [NUM_WARPS-1:0]    BrPending,
  output logic [15:0]             Stall_MULT_Cnt
);
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_WARPS-1:0] br_pend_q, br_pend_d;
  logic [15:0] stall_q, stall_d;
  logic [NUM_OC-1:0] br_ok, elig, gnt;
  logic [SEL_W-1:0] idx;
  logic any;
  logic [WID_W-1:0] g_warp;
  logic g_br;
  alu_issue_arbiter_rr_pick #(.N(NUM_OC)) u_pick (
    .elig(elig),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );
  always_comb begin
    br_ok = '0;
    elig = '0;
    g_warp = '0;
    g_br = 1'b0;
    for (int i = 0; i < NUM_OC; i++) begin
      br_ok[i] = Req_OC_Arb[i] & ~br_pend_q[WarpID_OC_Arb[i*WID_W +: WID_W]];
      elig[i] = br_ok[i] & ~(RegWrite_OC_Arb[i] & MULT_WB_Next);
      if (gnt[i]) begin
        g_warp = WarpID_OC_Arb[i*WID_W +: WID_W];
        g_br = IsBr_OC_Arb[i];
      end
    end
    rr_ptr_d = any ? idx + SEL_W'(1) : rr_ptr_q;
    br_pend_d = br_pend_q;
    if (any && g_br) br_pend_d[g_warp] = 1'b1;
    // Clear is applied last so it wins if a same-warp set is ever forced.
    if (Br_Done_SIMT) br_pend_d[Br_Done_WarpID_SIMT] = 1'b0;
    stall_d = (|br_ok && !any && MULT_WB_Next && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    Grant_Arb_OC = rst ? gnt : '0;
    Valid_OC_ALU = rst & any;
    Sel_OC_ALU = rst ? idx : '0;
    BrPending = br_pend_q;
    Stall_MULT_Cnt = stall_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      br_pend_q <= '0;
      stall_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      br_pend_q <= br_pend_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single ALU pipeline between NUM_OC operand-collector (OC) entries.
- Each cycle, grants at most one ready OC entry, round-robin, and drives the OC->ALU valid and source-select.
- Enforces two hazards:
  - CDB slot conflict with the MULT unit for register-writing ops.
  - One outstanding branch per warp until SIMT resolves it.
- Sits between the OC entries and the ALU; the ALU's input register captures the granted entry on the next edge.

Parameters:
- NUM_OC, 4, number of requesting OC entries (power of 2, 2..8).
- SEL_W, 2, log2(NUM_OC); derived, not overridden.
- NUM_WARPS, 8, warps tracked by the branch-pending table.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Req_OC_Arb  in  NUM_OC  entry i holds a complete ALU instruction.
- WarpID_OC_Arb  in  3*NUM_OC  flattened warp ID per entry; bits [3i+2:3i].
- IsBr_OC_Arb  in  NUM_OC  entry i is BEQ/BLT.
- RegWrite_OC_Arb  in  NUM_OC  entry i writes a register via the CDB.
- MULT_WB_Next  in  1  MULT will drive the CDB in cycle t+1.
- Br_Done_SIMT  in  1  SIMT has resolved a branch.
- Br_Done_WarpID_SIMT  in  3  warp whose branch resolved.
- Grant_Arb_OC  out  NUM_OC  one-hot grant, combinational; entry releases on grant.
- Valid_OC_ALU  out  1  equals |Grant_Arb_OC.
- Sel_OC_ALU  out  SEL_W  index of the granted entry; steers the OC->ALU payload mux.
- BrPending  out  NUM_WARPS  branch-pending bit per warp, registered.
- Stall_MULT_Cnt  out  16  saturating count of cycles a grant was blocked only by MULT_WB_Next.

Behaviour:
- Reset (rst low, async):
  - rr_ptr=0, BrPending=0, Stall_MULT_Cnt=0.
  - Grant_Arb_OC=0, Valid_OC_ALU=0, Sel_OC_ALU=0 (forced while rst low).
- Eligibility of entry i in cycle t (all terms required):
  - Req_OC_Arb[i]=1.
  - BrPending[WarpID_i]=0; this blocks every op of a warp with a branch in flight.
  - !(RegWrite_OC_Arb[i] & MULT_WB_Next). ALU result reaches the CDB at t+1, the same slot MULT claims. Branches do not write the CDB and are never blocked by MULT.
- Selection:
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_OC; grant the first eligible entry.
  - Zero or one grant per cycle; purely combinational from inputs and state (0-cycle latency).
  - No eligible entry: Grant=0, Valid=0, Sel holds 0.
- rr_ptr update at the edge:
  - If granted index k: rr_ptr <= (k+1) mod NUM_OC.
  - Otherwise rr_ptr holds.
  - Wrap-around: grant of NUM_OC-1 -> rr_ptr=0.
- BrPending update at the edge:
  - Set on a granted entry with IsBr=1: bit[WarpID_k] <= 1.
  - Clear on Br_Done_SIMT: bit[Br_Done_WarpID_SIMT] <= 0. Done for a non-pending warp has no effect.
  - Set and clear of different warps in the same cycle both take effect.
  - Same-warp set and clear in the same cycle cannot arise (the warp is ineligible while pending); if forced, clear wins.
- Stall_MULT_Cnt: increments (saturates at 0xFFFF) when:
  - at least one entry meets Req and the BrPending condition, and
  - none is eligible, and
  - MULT_WB_Next=1.
- Request stability:
  - A requester holds Req and fields until granted.
  - An ungranted request may be withdrawn only by OC flush; the arbiter tolerates it.
- Reset mid-operation:
  - All pending bits drop.
  - Any grant in that cycle is void.
  - ALU Valid_reg also resets, so nothing reaches the CDB.

Decomposition:
- Shared package:
  - NUM_WARPS and warp-ID width (3).
  - OC entry count and SEL_W.
  - a function returning the one-hot of the first set bit of a rotated vector.
- One sub-module, rr_pick: the rotate / priority-pick / rotate-back logic (inputs: eligible vector, rr_ptr; outputs: one-hot, index, any). Reusable for the CDB and MULT arbiters.
- Hazard masking, BrPending table and counter stay in the top.

Test Plan:
- Fairness: Req=4'b1111 held, all RegWrite, no hazards, 8 cycles -> Sel 0,1,2,3,0,1,2,3; Valid=1 every cycle; rr_ptr wraps 3->0.
- MULT conflict: Req=4'b0011; entry0 RegWrite, warp 2; entry1 branch, warp 5; rr_ptr=0; MULT_WB_Next=1 -> entry0 blocked, entry1 (branch) granted; Stall_MULT_Cnt unchanged. Then only entry0 requesting with MULT_WB_Next=1 -> no grant, Stall_MULT_Cnt +1.
- Branch lock: grant branch for warp 3 -> BrPending=8'h08. Warp-3 ALU op on entry2 ignored for 5 cycles; warp-1 op on entry0 still granted. Br_Done_SIMT with WarpID=3 -> BrPending=0; entry2 granted the next cycle.
- Simultaneous: BrPending=8'h02; grant branch for warp 6 and Br_Done for warp 1 in the same cycle -> BrPending=8'h40.
- Async reset: assert rst low mid-cycle with Req=4'b1111, BrPending=8'hFF -> Grant=0, Valid=0, BrPending=0, rr_ptr=0 immediately. After release, first grant is entry 0.
